mc_ctrl: RTL and testbench

MC_CTRL -- requirements
Module: mc_ctrl

---
 rtl/mc_pkg.sv | 61 ++++++
 rtl/mc_decode.sv | 31 +++
 rtl/mc_ctrl.sv | 157 +++++++++++++++
 tb/tb_mc_ctrl.sv | 365 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mc_pkg.sv
// mc_pkg: shared types for the multicycle controller.
// State encoding, opcode/func constants, mux select encodings, class vector.
package mc_pkg;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_JAL   = 6'b000011;

  localparam logic [5:0] FN_ADDU  = 6'b100001;
  localparam logic [5:0] FN_SUBU  = 6'b100011;
  localparam logic [5:0] FN_JR    = 6'b001000;

  localparam logic [1:0] NPC_PC4  = 2'b00;
  localparam logic [1:0] NPC_BR   = 2'b01;
  localparam logic [1:0] NPC_J    = 2'b10;
  localparam logic [1:0] NPC_RS   = 2'b11;

  localparam logic [1:0] WD_ALU   = 2'b00;
  localparam logic [1:0] WD_DM    = 2'b01;
  localparam logic [1:0] WD_LUI   = 2'b10;
  localparam logic [1:0] WD_PC4   = 2'b11;

  localparam logic [1:0] RD_RT    = 2'b00;
  localparam logic [1:0] RD_RD    = 2'b01;
  localparam logic [1:0] RD_RA    = 2'b10;

  localparam logic [1:0] ALU_ADD  = 2'b00;
  localparam logic [1:0] ALU_SUB  = 2'b01;
  localparam logic [1:0] ALU_OR   = 2'b10;

  // Exactly one field is set for any op/func pair.
  typedef struct packed {
    logic jal;
    logic lui;
    logic beq;
    logic sw;
    logic lw;
    logic ori;
    logic jr;
    logic subu;
    logic addu;
    logic nop;
  } cls_t;

  function automatic logic skips_exec(cls_t c);
    return c.lui | c.jal;
  endfunction

endpackage

// File: rtl/mc_decode.sv
// mc_decode: op/func -> one-hot instruction class.
// in: op, func  out: cls (anything unrecognised is nop).
module mc_decode
  import mc_pkg::*;
(
  input  logic [5:0] op,
  input  logic [5:0] func,
  output cls_t       cls
);

  logic rtype;

  assign rtype = (op == OP_RTYPE);

  always_comb begin
    cls = '0;
    unique case (1'b1)
      (rtype && func == FN_ADDU): cls.addu = 1'b1;
      (rtype && func == FN_SUBU): cls.subu = 1'b1;
      (rtype && func == FN_JR):   cls.jr   = 1'b1;
      (op == OP_ORI):             cls.ori  = 1'b1;
      (op == OP_LW):              cls.lw   = 1'b1;
      (op == OP_SW):              cls.sw   = 1'b1;
      (op == OP_BEQ):             cls.beq  = 1'b1;
      (op == OP_LUI):             cls.lui  = 1'b1;
      (op == OP_JAL):             cls.jal  = 1'b1;
      default:                    cls.nop  = 1'b1;
    endcase
  end

endmodule

// File: rtl/mc_ctrl.sv
// mc_ctrl: multicycle FETCH/DECODE/EXEC/MEM/WB controller with retire count.
// in: clk, reset, op, func, zero, dm_ack  out: datapath strobes, state, retire, instr_cnt.
module mc_ctrl
  import mc_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [5:0]       op,
  input  logic [5:0]       func,
  input  logic             zero,
  input  logic             dm_ack,
  output logic             IRWrite,
  output logic             PCWrite,
  output logic [1:0]       NPCsel,
  output logic             RegWrite,
  output logic [1:0]       RegDst,
  output logic [1:0]       WDsel,
  output logic             ALUsrcB,
  output logic [1:0]       ALUop,
  output logic             ExtOp,
  output logic             dm_req,
  output logic             dm_we,
  output logic [2:0]       state,
  output logic             retire,
  output logic [CNT_W-1:0] instr_cnt
);

  cls_t   cls;
  state_t state_q;
  state_t state_d;

  mc_decode u_decode (
    .op   (op),
    .func (func),
    .cls  (cls)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    IRWrite  = 1'b0;
    PCWrite  = 1'b0;
    NPCsel   = NPC_PC4;
    RegWrite = 1'b0;
    RegDst   = RD_RT;
    WDsel    = WD_ALU;
    ALUsrcB  = 1'b0;
    ALUop    = ALU_ADD;
    ExtOp    = 1'b0;
    dm_req   = 1'b0;
    dm_we    = 1'b0;
    unique case (state_q)
      S_FETCH: begin
        IRWrite = 1'b1;
        state_d = S_DECODE;
      end
      S_DECODE: begin
        if (cls.nop) begin
          PCWrite = 1'b1;
          state_d = S_FETCH;
        end else if (skips_exec(cls)) begin
          state_d = S_WB;
        end else begin
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        unique case (1'b1)
          cls.addu: begin
            ExtOp   = 1'b1;
            state_d = S_WB;
          end
          cls.subu: begin
            ALUop   = ALU_SUB;
            ExtOp   = 1'b1;
            state_d = S_WB;
          end
          cls.ori: begin
            ALUop   = ALU_OR;
            ALUsrcB = 1'b1;
            state_d = S_WB;
          end
          cls.lw, cls.sw: begin
            ALUsrcB = 1'b1;
            ExtOp   = 1'b1;
            state_d = S_MEM;
          end
          cls.beq: begin
            ALUop   = ALU_SUB;
            ExtOp   = 1'b1;
            PCWrite = 1'b1;
            NPCsel  = zero ? NPC_BR : NPC_PC4;
            state_d = S_FETCH;
          end
          cls.jr: begin
            PCWrite = 1'b1;
            NPCsel  = NPC_RS;
            state_d = S_FETCH;
          end
          // Other classes never reach EXEC; fall back to a fetch.
          default: state_d = S_FETCH;
        endcase
      end
      S_MEM: begin
        dm_req = 1'b1;
        dm_we  = cls.sw;
        if (dm_ack) begin
          if (cls.sw) begin
            PCWrite = 1'b1;
            state_d = S_FETCH;
          end else begin
            state_d = S_WB;
          end
        end
      end
      S_WB: begin
        RegWrite = 1'b1;
        PCWrite  = 1'b1;
        state_d  = S_FETCH;
        unique case (1'b1)
          cls.addu, cls.subu: RegDst = RD_RD;
          cls.lw:  WDsel = WD_DM;
          cls.lui: WDsel = WD_LUI;
          cls.jal: begin
            RegDst = RD_RA;
            WDsel  = WD_PC4;
            NPCsel = NPC_J;
          end
          default: ;
        endcase
      end
      default: state_d = S_FETCH;
    endcase
  end

  // Every instruction writes PC exactly once, so PCWrite is the retire pulse.
  assign retire = PCWrite;
  assign state  = state_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      instr_cnt <= '0;
    end else if (retire) begin
      instr_cnt <= instr_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_mc_ctrl.sv
// tb_mc_ctrl: directed per-cycle checks of mc_ctrl (CNT_W=4).
// Each task walks an instruction table and compares state/strobes.
module tb_mc_ctrl;

  localparam logic [2:0] F = 3'd0;
  localparam logic [2:0] D = 3'd1;
  localparam logic [2:0] E = 3'd2;
  localparam logic [2:0] M = 3'd3;
  localparam logic [2:0] W = 3'd4;

  // {IRWrite,PCWrite,NPCsel,RegWrite,RegDst,WDsel,ALUsrcB,ALUop,ExtOp,dm_req,dm_we}
  localparam logic [14:0] O_F    = 15'b1_0_00_0_00_00_0_00_0_0_0;
  localparam logic [14:0] O_Z    = 15'b0_0_00_0_00_00_0_00_0_0_0;
  localparam logic [14:0] O_NOP  = 15'b0_1_00_0_00_00_0_00_0_0_0;
  localparam logic [14:0] O_EADD = 15'b0_0_00_0_00_00_0_00_1_0_0;
  localparam logic [14:0] O_ESUB = 15'b0_0_00_0_00_00_0_01_1_0_0;
  localparam logic [14:0] O_EOR  = 15'b0_0_00_0_00_00_1_10_0_0_0;
  localparam logic [14:0] O_EMEM = 15'b0_0_00_0_00_00_1_00_1_0_0;
  localparam logic [14:0] O_EBQ1 = 15'b0_1_01_0_00_00_0_01_1_0_0;
  localparam logic [14:0] O_EBQ0 = 15'b0_1_00_0_00_00_0_01_1_0_0;
  localparam logic [14:0] O_EJR  = 15'b0_1_11_0_00_00_0_00_0_0_0;
  localparam logic [14:0] O_MLW  = 15'b0_0_00_0_00_00_0_00_0_1_0;
  localparam logic [14:0] O_MSW  = 15'b0_0_00_0_00_00_0_00_0_1_1;
  localparam logic [14:0] O_MSWR = 15'b0_1_00_0_00_00_0_00_0_1_1;
  localparam logic [14:0] O_WRD  = 15'b0_1_00_1_01_00_0_00_0_0_0;
  localparam logic [14:0] O_WRT  = 15'b0_1_00_1_00_00_0_00_0_0_0;
  localparam logic [14:0] O_WLW  = 15'b0_1_00_1_00_01_0_00_0_0_0;
  localparam logic [14:0] O_WLUI = 15'b0_1_00_1_00_10_0_00_0_0_0;
  localparam logic [14:0] O_WJAL = 15'b0_1_10_1_10_11_0_00_0_0_0;

  typedef struct packed {
    logic [5:0]  op;
    logic [5:0]  fn;
    logic        z;
    logic        ack;
    logic [2:0]  st;
    logic [14:0] ex;
  } row_t;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] op;
  logic [5:0] func;
  logic       zero;
  logic       dm_ack;
  logic       IRWrite, PCWrite, RegWrite, ALUsrcB, ExtOp;
  logic       dm_req, dm_we, retire;
  logic [1:0] NPCsel, RegDst, WDsel, ALUop;
  logic [2:0] state;
  logic [3:0] instr_cnt;

  int         n_cmp = 0;
  int         n_bad = 0;
  logic [3:0] exp_cnt = 4'd0;

  always #5 clk = ~clk;

  mc_ctrl #(.CNT_W(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .op        (op),
    .func      (func),
    .zero      (zero),
    .dm_ack    (dm_ack),
    .IRWrite   (IRWrite),
    .PCWrite   (PCWrite),
    .NPCsel    (NPCsel),
    .RegWrite  (RegWrite),
    .RegDst    (RegDst),
    .WDsel     (WDsel),
    .ALUsrcB   (ALUsrcB),
    .ALUop     (ALUop),
    .ExtOp     (ExtOp),
    .dm_req    (dm_req),
    .dm_we     (dm_we),
    .state     (state),
    .retire    (retire),
    .instr_cnt (instr_cnt)
  );

  function automatic logic [14:0] outs();
    return {IRWrite, PCWrite, NPCsel, RegWrite, RegDst,
            WDsel, ALUsrcB, ALUop, ExtOp, dm_req, dm_we};
  endfunction

  function automatic row_t mk(input logic [5:0] o, input logic [5:0] f,
                              input logic z, input logic a,
                              input logic [2:0] s, input logic [14:0] e);
    row_t r;
    r.op = o; r.fn = f; r.z = z; r.ack = a; r.st = s; r.ex = e;
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; op = 6'd0; func = 6'd0; zero = 1'b0; dm_ack = 1'b1;
    tick();
    tick();
    n_cmp++;
    if (state !== F || instr_cnt !== 4'd0) begin
      n_bad++;
      $display("FAIL reset: state=%0d cnt=%0d required state=0 cnt=0",
               state, instr_cnt);
    end
    reset = 1'b0;
    #1;
    n_cmp++;
    if (state !== F || outs() !== O_F || retire !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_first_fetch: state=%0d outs=%b required 0 %b",
               state, outs(), O_F);
    end
  endtask

  task automatic test_addu();
    row_t v[$];
    v.push_back(mk(6'b000000, 6'b100001, 0, 1, F, O_F));
    v.push_back(mk(6'b000000, 6'b100001, 0, 1, D, O_Z));
    v.push_back(mk(6'b000000, 6'b100001, 0, 1, E, O_EADD));
    v.push_back(mk(6'b000000, 6'b100001, 0, 1, W, O_WRD));
    foreach (v[i]) begin
      op = v[i].op; func = v[i].fn; zero = v[i].z; dm_ack = v[i].ack;
      #1;
      n_cmp++;
      if (state !== v[i].st || outs() !== v[i].ex || retire !== v[i].ex[13]) begin
        n_bad++;
        $display("FAIL addu row %0d: state=%0d outs=%b required state=%0d outs=%b",
                 i, state, outs(), v[i].st, v[i].ex);
      end
      tick();
    end
    exp_cnt = exp_cnt + 4'd1;
    n_cmp++;
    if (instr_cnt !== exp_cnt || state !== F) begin
      n_bad++;
      $display("FAIL addu_cnt: cnt=%0d state=%0d required cnt=%0d state=0",
               instr_cnt, state, exp_cnt);
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    exp_cnt = 4'd0;
    n_cmp++;
    if (instr_cnt !== exp_cnt || state !== F) begin
      n_bad++;
      $display("FAIL addu_reset: cnt=%0d state=%0d required cnt=0 state=0",
               instr_cnt, state);
    end
  endtask

  task automatic test_lw_wait();
    row_t v[$];
    v.push_back(mk(6'b100011, 6'd0, 0, 0, F, O_F));
    v.push_back(mk(6'b100011, 6'd0, 0, 0, D, O_Z));
    v.push_back(mk(6'b100011, 6'd0, 0, 0, E, O_EMEM));
    v.push_back(mk(6'b100011, 6'd0, 0, 0, M, O_MLW));
    v.push_back(mk(6'b100011, 6'd0, 0, 0, M, O_MLW));
    v.push_back(mk(6'b100011, 6'd0, 0, 0, M, O_MLW));
    v.push_back(mk(6'b100011, 6'd0, 0, 1, M, O_MLW));
    v.push_back(mk(6'b100011, 6'd0, 0, 0, W, O_WLW));
    foreach (v[i]) begin
      op = v[i].op; func = v[i].fn; zero = v[i].z; dm_ack = v[i].ack;
      #1;
      n_cmp++;
      if (state !== v[i].st || outs() !== v[i].ex || retire !== v[i].ex[13]) begin
        n_bad++;
        $display("FAIL lw_wait row %0d: state=%0d outs=%b required state=%0d outs=%b",
                 i, state, outs(), v[i].st, v[i].ex);
      end
      tick();
    end
    exp_cnt = exp_cnt + 4'd1;
    n_cmp++;
    if (instr_cnt !== exp_cnt || state !== F) begin
      n_bad++;
      $display("FAIL lw_cnt: cnt=%0d state=%0d required cnt=%0d state=0",
               instr_cnt, state, exp_cnt);
    end
  endtask

  task automatic test_beq();
    row_t v[$];
    v.push_back(mk(6'b000100, 6'd0, 1, 0, F, O_F));
    v.push_back(mk(6'b000100, 6'd0, 1, 0, D, O_Z));
    v.push_back(mk(6'b000100, 6'd0, 1, 0, E, O_EBQ1));
    v.push_back(mk(6'b000100, 6'd0, 0, 0, F, O_F));
    v.push_back(mk(6'b000100, 6'd0, 0, 0, D, O_Z));
    v.push_back(mk(6'b000100, 6'd0, 0, 0, E, O_EBQ0));
    foreach (v[i]) begin
      op = v[i].op; func = v[i].fn; zero = v[i].z; dm_ack = v[i].ack;
      #1;
      n_cmp++;
      if (state !== v[i].st || outs() !== v[i].ex || retire !== v[i].ex[13]) begin
        n_bad++;
        $display("FAIL beq row %0d: state=%0d outs=%b required state=%0d outs=%b",
                 i, state, outs(), v[i].st, v[i].ex);
      end
      tick();
    end
    exp_cnt = exp_cnt + 4'd2;
    n_cmp++;
    if (instr_cnt !== exp_cnt || state !== F) begin
      n_bad++;
      $display("FAIL beq_cnt: cnt=%0d state=%0d required cnt=%0d state=0",
               instr_cnt, state, exp_cnt);
    end
  endtask

  task automatic test_jal_jr();
    row_t v[$];
    v.push_back(mk(6'b000011, 6'd0, 0, 0, F, O_F));
    v.push_back(mk(6'b000011, 6'd0, 0, 0, D, O_Z));
    v.push_back(mk(6'b000011, 6'd0, 0, 0, W, O_WJAL));
    v.push_back(mk(6'b000000, 6'b001000, 0, 0, F, O_F));
    v.push_back(mk(6'b000000, 6'b001000, 0, 0, D, O_Z));
    v.push_back(mk(6'b000000, 6'b001000, 0, 0, E, O_EJR));
    foreach (v[i]) begin
      op = v[i].op; func = v[i].fn; zero = v[i].z; dm_ack = v[i].ack;
      #1;
      n_cmp++;
      if (state !== v[i].st || outs() !== v[i].ex || retire !== v[i].ex[13]) begin
        n_bad++;
        $display("FAIL jal_jr row %0d: state=%0d outs=%b required state=%0d outs=%b",
                 i, state, outs(), v[i].st, v[i].ex);
      end
      tick();
    end
    exp_cnt = exp_cnt + 4'd2;
    n_cmp++;
    if (instr_cnt !== exp_cnt || state !== F) begin
      n_bad++;
      $display("FAIL jal_jr_cnt: cnt=%0d state=%0d required cnt=%0d state=0",
               instr_cnt, state, exp_cnt);
    end
  endtask

  task automatic test_back_to_back();
    row_t v[$];
    v.push_back(mk(6'b000000, 6'b100011, 0, 0, F, O_F));
    v.push_back(mk(6'b000000, 6'b100011, 0, 0, D, O_Z));
    v.push_back(mk(6'b000000, 6'b100011, 0, 0, E, O_ESUB));
    v.push_back(mk(6'b000000, 6'b100011, 0, 0, W, O_WRD));
    v.push_back(mk(6'b001101, 6'b100001, 0, 0, F, O_F));
    v.push_back(mk(6'b001101, 6'b100001, 0, 0, D, O_Z));
    v.push_back(mk(6'b001101, 6'b100001, 0, 0, E, O_EOR));
    v.push_back(mk(6'b001101, 6'b100001, 0, 0, W, O_WRT));
    v.push_back(mk(6'b001111, 6'd0, 0, 0, F, O_F));
    v.push_back(mk(6'b001111, 6'd0, 0, 0, D, O_Z));
    v.push_back(mk(6'b001111, 6'd0, 0, 0, W, O_WLUI));
    v.push_back(mk(6'b101011, 6'd0, 0, 1, F, O_F));
    v.push_back(mk(6'b101011, 6'd0, 0, 1, D, O_Z));
    v.push_back(mk(6'b101011, 6'd0, 0, 1, E, O_EMEM));
    v.push_back(mk(6'b101011, 6'd0, 0, 1, M, O_MSWR));
    v.push_back(mk(6'b000000, 6'b000000, 1, 1, F, O_F));
    v.push_back(mk(6'b000000, 6'b000000, 1, 1, D, O_NOP));
    foreach (v[i]) begin
      op = v[i].op; func = v[i].fn; zero = v[i].z; dm_ack = v[i].ack;
      #1;
      n_cmp++;
      if (state !== v[i].st || outs() !== v[i].ex || retire !== v[i].ex[13]) begin
        n_bad++;
        $display("FAIL b2b row %0d: state=%0d outs=%b required state=%0d outs=%b",
                 i, state, outs(), v[i].st, v[i].ex);
      end
      tick();
    end
    exp_cnt = exp_cnt + 4'd5;
    n_cmp++;
    if (instr_cnt !== exp_cnt || state !== F) begin
      n_bad++;
      $display("FAIL b2b_cnt: cnt=%0d state=%0d required cnt=%0d state=0",
               instr_cnt, state, exp_cnt);
    end
  endtask

  task automatic test_sw_reset();
    row_t v[$];
    v.push_back(mk(6'b101011, 6'd0, 0, 0, F, O_F));
    v.push_back(mk(6'b101011, 6'd0, 0, 0, D, O_Z));
    v.push_back(mk(6'b101011, 6'd0, 0, 0, E, O_EMEM));
    v.push_back(mk(6'b101011, 6'd0, 0, 0, M, O_MSW));
    foreach (v[i]) begin
      op = v[i].op; func = v[i].fn; zero = v[i].z; dm_ack = v[i].ack;
      #1;
      n_cmp++;
      if (state !== v[i].st || outs() !== v[i].ex || retire !== v[i].ex[13]) begin
        n_bad++;
        $display("FAIL sw_reset row %0d: state=%0d outs=%b required state=%0d outs=%b",
                 i, state, outs(), v[i].st, v[i].ex);
      end
      tick();
    end
    reset = 1'b1;
    #1;
    n_cmp++;
    if (state !== M || outs() !== O_MSW) begin
      n_bad++;
      $display("FAIL sw_mem2: state=%0d outs=%b required state=3 outs=%b",
               state, outs(), O_MSW);
    end
    tick();
    reset = 1'b0;
    exp_cnt = 4'd0;
    #1;
    n_cmp++;
    if (state !== F || dm_req !== 1'b0 || PCWrite !== 1'b0 ||
        instr_cnt !== exp_cnt || outs() !== O_F) begin
      n_bad++;
      $display("FAIL sw_abort: state=%0d dm_req=%b pcw=%b cnt=%0d required 0 0 0 0",
               state, dm_req, PCWrite, instr_cnt);
    end
  endtask

  task automatic test_nop_wrap();
    op = 6'b111111; func = 6'b111111; zero = 1'b0; dm_ack = 1'b0;
    for (int k = 0; k < 16; k++) begin
      #1;
      n_cmp++;
      if (state !== F || outs() !== O_F) begin
        n_bad++;
        $display("FAIL nop_fetch %0d: state=%0d outs=%b required 0 %b",
                 k, state, outs(), O_F);
      end
      tick();
      #1;
      n_cmp++;
      if (state !== D || outs() !== O_NOP || retire !== 1'b1) begin
        n_bad++;
        $display("FAIL nop_decode %0d: state=%0d outs=%b required 1 %b",
                 k, state, outs(), O_NOP);
      end
      tick();
      exp_cnt = exp_cnt + 4'd1;
      n_cmp++;
      if (instr_cnt !== exp_cnt) begin
        n_bad++;
        $display("FAIL nop_cnt %0d: cnt=%0d required %0d", k, instr_cnt, exp_cnt);
      end
    end
    n_cmp++;
    if (instr_cnt !== 4'd0) begin
      n_bad++;
      $display("FAIL nop_wrap: cnt=%0d required 0", instr_cnt);
    end
  endtask

  initial begin
    reset = 1'b1; op = 6'd0; func = 6'd0; zero = 1'b0; dm_ack = 1'b0;
    test_reset();
    test_addu();
    test_lw_wait();
    test_beq();
    test_jal_jr();
    test_back_to_back();
    test_sw_reset();
    test_nop_wrap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
